// File: rtl/key_cmd_capture.sv
// key_cmd_capture
// Captures user commands from the DE1-SoC push-buttons and slide switches.
// Each of the two active-low keys is synchronised and debounced. On every
// debounced press, {key_id, switch value} is written into a small command
// FIFO. The downstream decoder drains that FIFO over a valid/ready handshake.
//
// Ports
//   Clock       in   system clock (CLOCK_50 domain)
//   nReset      in   asynchronous active-low reset; deassertion is
//                    synchronised internally
//   KEY_n       in   raw push-buttons, active low, asynchronous
//   SW          in   raw slide switches
//   cmd_data    out  {key_id, sw_value} at the FIFO head
//   cmd_valid   out  FIFO head valid
//   cmd_ready   in   consumer accepts the head
//   fifo_level  out  current FIFO occupancy, 0..FIFO_DEPTH
//   overflow    out  sticky flag: a press was dropped because the FIFO was
//                    full; cleared only by reset
//
// Build option
//   KEY_CMD_SW_SYNC_EN  When defined, SW passes through a 2-flop synchroniser
//                       before the capture register, so the captured value is
//                       SW as it was two cycles before the press pulse. When
//                       not defined, SW is captured directly at the
//                       press-pulse edge.
//
// Write arbiter states
//   state  | meaning
//   S_IDLE | no press is waiting; a new press is written immediately
//   S_PEND | one press is parked in the pending register; it is written
//            this cycle

module key_cmd_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          Clock,
    input  logic                          nReset,
    input  logic [1:0]                    KEY_n,
    input  logic [SW_WIDTH-1:0]           SW,
    output logic [SW_WIDTH:0]             cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = SW_WIDTH + 1;

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

    // Internal reset: asserts asynchronously with nReset and releases
    // two clock edges after nReset rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // ---------------- key synchronise / debounce / press detect ------------
    logic [1:0]    r_key_s1;
    logic [1:0]    r_key_s2;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_d;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_deb    <= '0;
            r_deb_d  <= '0;
            r_press  <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_key_s1 <= ~KEY_n;
            r_key_s2 <= r_key_s1;
            r_deb_d  <= r_deb;
            // The press pulse is registered, so it lands one edge after the
            // debounced level rises.
            r_press  <= r_deb & ~r_deb_d;
            for (int k = 0; k < 2; k++) begin
                if (r_key_s2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[k] <= ~r_deb[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    // ---------------- switch capture ---------------------------------------
    logic [SW_WIDTH-1:0] w_sw_in;
    logic [SW_WIDTH-1:0] r_sw;

`ifdef KEY_CMD_SW_SYNC_EN
    logic [SW_WIDTH-1:0] r_sw_s1;
    logic [SW_WIDTH-1:0] r_sw_s2;

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign w_sw_in = r_sw_s2;
`else
    assign w_sw_in = SW;
`endif

    // r_sw is loaded on the same edge as r_press, so it holds the switch
    // value that belongs to the press.
    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) r_sw <= '0;
        else          r_sw <= w_sw_in;
    end

    // ---------------- write arbiter (pending register) ---------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_pend_data;
    logic          w_wr_en;
    logic [DW-1:0] w_wr_data;
    logic          w_pend_load;
    logic [DW-1:0] w_pend_data;
    logic [DW-1:0] w_k0_data;
    logic [DW-1:0] w_k1_data;

    assign w_k0_data = {1'b0, r_sw};
    assign w_k1_data = {1'b1, r_sw};

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_press[0] && r_press[1]) w_state_nxt = S_PEND;
            S_PEND: w_state_nxt = (r_press[0] || r_press[1]) ? S_PEND : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        w_pend_load = 1'b0;
        w_pend_data = '0;
        case (r_state)
            S_IDLE: begin
                if (r_press[0]) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_k0_data;
                    if (r_press[1]) begin
                        w_pend_load = 1'b1;
                        w_pend_data = w_k1_data;
                    end
                end else if (r_press[1]) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_k1_data;
                end
            end
            S_PEND: begin
                // The parked entry goes first. A new press is parked in its
                // place and is written on the next cycle.
                w_wr_en   = 1'b1;
                w_wr_data = r_pend_data;
                if (r_press[0]) begin
                    w_pend_load = 1'b1;
                    w_pend_data = w_k0_data;
                end else if (r_press[1]) begin
                    w_pend_load = 1'b1;
                    w_pend_data = w_k1_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n)         r_pend_data <= '0;
        else if (w_pend_load) r_pend_data <= w_pend_data;
    end

    // ---------------- command FIFO -----------------------------------------
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full = (r_count == LW'(FIFO_DEPTH));
    assign w_pop  = cmd_valid && cmd_ready;
    // When the FIFO is full, a simultaneous pop frees the head slot. That
    // slot is the write slot, so the push still succeeds.
    assign w_push = w_wr_en && (!w_full || w_pop);

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
            if (w_wr_en && !w_push) r_overflow <= 1'b1;
        end
    end

    assign cmd_valid  = (r_count != '0);
    assign cmd_data   = r_mem[r_rd_ptr];
    assign fifo_level = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_key_cmd_capture.sv
// Directed testbench for key_cmd_capture with the default parameters
// (DEBOUNCE_CYCLES=16, SW_WIDTH=10, FIFO_DEPTH=4).
module tb_key_cmd_capture;

    logic        Clock     = 1'b0;
    logic        nReset    = 1'b0;
    logic [1:0]  KEY_n     = 2'b11;
    logic [9:0]  SW        = '0;
    logic        cmd_ready = 1'b0;
    logic [10:0] cmd_data;
    logic        cmd_valid;
    logic [2:0]  fifo_level;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int n;
    int saw;

    key_cmd_capture dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .KEY_n      (KEY_n),
        .SW         (SW),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic press_key0(input logic [9:0] sw_val);
        SW    = sw_val;
        KEY_n = 2'b10;
        tick(25);
        KEY_n = 2'b11;
        tick(25);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_data", 32'(cmd_data), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        #10;
        nReset = 1'b1;
        tick(3);

        // Idle: no key activity for 1000 cycles
        saw = 0;
        repeat (1000) begin
            tick(1);
            if (cmd_valid) saw = 1;
        end
        chk("idle_valid", 32'(saw), 32'h0);

        // Single key-0 press: latency and captured data
        SW    = 10'h005;
        KEY_n = 2'b10;
        n     = 0;
        while (!cmd_valid && n < 100) begin
            tick(1);
            n++;
        end
        chk("latency", 32'(n), 32'd20);
        chk("k0_data", 32'(cmd_data), 32'h005);
        chk("k0_level", 32'(fifo_level), 32'h1);
        tick(30);
        KEY_n = 2'b11;
        tick(40);
        chk("release_no_event", 32'(fifo_level), 32'h1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("pop_level", 32'(fifo_level), 32'h0);
        chk("pop_valid", 32'(cmd_valid), 32'h0);

        // Key-1 bounce, then a real press
        SW = 10'h3FF;
        repeat (5) begin
            KEY_n = 2'b01;
            tick(3);
            KEY_n = 2'b11;
            tick(3);
        end
        tick(25);
        chk("glitch_level", 32'(fifo_level), 32'h0);
        KEY_n = 2'b01;
        tick(50);
        KEY_n = 2'b11;
        tick(30);
        chk("k1_level", 32'(fifo_level), 32'h1);
        chk("k1_data", 32'(cmd_data), 32'h7FF);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("k1_pop_level", 32'(fifo_level), 32'h0);

        // Both keys fall together
        SW    = 10'h00C;
        KEY_n = 2'b00;
        n     = 0;
        while (!cmd_valid && n < 100) begin
            tick(1);
            n++;
        end
        chk("both_first_data", 32'(cmd_data), 32'h00C);
        chk("both_first_level", 32'(fifo_level), 32'h1);
        tick(1);
        chk("both_second_level", 32'(fifo_level), 32'h2);
        cmd_ready = 1'b1;
        tick(1);
        chk("both_second_data", 32'(cmd_data), 32'h40C);
        tick(1);
        cmd_ready = 1'b0;
        chk("both_drained", 32'(cmd_valid), 32'h0);
        tick(20);
        KEY_n = 2'b11;
        tick(30);

        // Overflow: six presses with no consumer
        cmd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            press_key0(10'(i));
            if (i == 4) begin
                chk("fill4_level", 32'(fifo_level), 32'h4);
                chk("fill4_ovf", 32'(overflow), 32'h0);
            end
        end
        chk("ovf_level", 32'(fifo_level), 32'h4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(cmd_data), 32'(i));
            tick(1);
        end
        cmd_ready = 1'b0;
        chk("drain_level", 32'(fifo_level), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        nReset = 1'b0;
        #1;
        chk("ovf_cleared", 32'(overflow), 32'h0);
        #3;
        nReset = 1'b1;
        tick(3);

        // Full FIFO: push coincident with pop
        for (int i = 7; i <= 10; i++) press_key0(10'(i));
        chk("full_level", 32'(fifo_level), 32'h4);
        SW    = 10'h00B;
        KEY_n = 2'b10;
        tick(19);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("pushpop_level", 32'(fifo_level), 32'h4);
        chk("pushpop_ovf", 32'(overflow), 32'h0);
        chk("pushpop_head", 32'(cmd_data), 32'h008);
        KEY_n = 2'b11;
        tick(25);
        chk("pushpop_stable", 32'(fifo_level), 32'h4);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("three_level", 32'(fifo_level), 32'h3);
        chk("three_head", 32'(cmd_data), 32'h009);

        // Asynchronous reset with entries queued
        nReset = 1'b0;
        #1;
        chk("async_valid", 32'(cmd_valid), 32'h0);
        chk("async_level", 32'(fifo_level), 32'h0);
        chk("async_data", 32'(cmd_data), 32'h0);
        #3;
        nReset = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
